// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- bundle of all requester, response and shared-memory
// signals around dmem_arbiter.
//   slave  : arbiter side (takes requests and mem_read_data, drives acks,
//            rdata, busy, owner and the memory strobes)
//   master : requester/memory side (the mirror image)
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              owner;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
      output ack0, ack1, rdata, busy, owner,
             mem_address, mem_write_data, mem_read, mem_write
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
      input  ack0, ack1, rdata, busy, owner,
             mem_address, mem_write_data, mem_read, mem_write
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-requester arbiter in front of a single data memory.
// Each transaction takes three cycles: IDLE (grant) -> ACCESS (memory
// strobe) -> RESP (one-cycle ack to the winner).
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave -- req/we/addr/wdata from requesters 0/1,
//            ack0/ack1, rdata, busy, owner, and the memory port
//            (mem_address, mem_write_data, mem_read, mem_write,
//            mem_read_data; memory reads combinationally, writes on clk)
//
// Build option:
//   DMEM_ARB_RR_EN -- round-robin between simultaneous requests. When
//   undefined, requester 0 always wins a tie and no pointer flop exists.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state;
   logic              grant1;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

`ifdef DMEM_ARB_RR_EN
   // Index of the last granted requester; resets to 1 so requester 0
   // wins the first tie.
   logic last_q;

   always_comb begin
      grant1 = bus.req1 & (~bus.req0 | ~last_q);
   end
`else
   always_comb begin
      grant1 = bus.req1 & ~bus.req0;
   end
`endif

   always_comb begin
      win_we    = grant1 ? bus.we1    : bus.we0;
      win_addr  = grant1 ? bus.addr1  : bus.addr0;
      win_wdata = grant1 ? bus.wdata1 : bus.wdata0;
   end

   // The memory strobe registers double as the latched transaction: they
   // are loaded at the grant and cleared after the single ACCESS cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         bus.ack0           <= 1'b0;
         bus.ack1           <= 1'b0;
         bus.busy           <= 1'b0;
         bus.owner          <= 1'b0;
         bus.rdata          <= '0;
         bus.mem_address    <= '0;
         bus.mem_write_data <= '0;
         bus.mem_read       <= 1'b0;
         bus.mem_write      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_q             <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state              <= ACCESS;
                  bus.busy           <= 1'b1;
                  bus.owner          <= grant1;
                  bus.mem_address    <= win_addr;
                  bus.mem_write_data <= win_wdata;
                  bus.mem_write      <= win_we;
                  bus.mem_read       <= ~win_we;
`ifdef DMEM_ARB_RR_EN
                  last_q             <= grant1;
`endif
               end
            end
            ACCESS: begin
               state              <= RESP;
               if (bus.mem_read) begin
                  bus.rdata <= bus.mem_read_data;
               end
               bus.ack0           <= ~bus.owner;
               bus.ack1           <= bus.owner;
               bus.mem_address    <= '0;
               bus.mem_write_data <= '0;
               bus.mem_read       <= 1'b0;
               bus.mem_write      <= 1'b0;
            end
            RESP: begin
               state    <= IDLE;
               bus.ack0 <= 1'b0;
               bus.ack1 <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed bench for dmem_arbiter: a table of single
// transactions followed by hand-written multi-cycle sequences (reset during
// ACCESS, input change after grant, contention, back-to-back requests).
// Expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared memory model: 64 words, combinational read, write on clk.
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
   end
   assign bus.mem_read_data = mem[bus.mem_address[7:2]];

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack0"},  {31'd0, bus.ack0}, 32'd0);
      chk({tag, "_ack1"},  {31'd0, bus.ack1}, 32'd0);
      chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
      chk({tag, "_owner"}, {31'd0, bus.owner}, 32'd0);
      chk({tag, "_mrd"},   {31'd0, bus.mem_read}, 32'd0);
      chk({tag, "_mwr"},   {31'd0, bus.mem_write}, 32'd0);
      chk({tag, "_maddr"}, bus.mem_address, 32'd0);
      chk({tag, "_mwd"},   bus.mem_write_data, 32'd0);
      chk({tag, "_rdata"}, bus.rdata, 32'd0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle_timeout"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic clear_inputs();
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
   endtask

   typedef struct {
      logic        r0;
      logic        w0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic        r1;
      logic        w1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic        eo;   // expected winner
      logic        ewe;  // expected mem_write
      logic [31:0] ea;   // expected mem_address
      logic [31:0] ed;   // expected mem_write_data
      logic [31:0] erd;  // expected rdata in RESP
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b1, 1'b1, 32'h00, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b1, 32'h00, 32'hAABBCCDD, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b1, 32'h10, 32'h12345678, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00, 32'h0,
                  1'b1, 1'b0, 32'h00, 32'h0, 32'hAABBCCDD};
      vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678};
      vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h5A5A5A5A,
                  1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0,
                  1'b0, 1'b0, 32'h00, 32'h0, 32'hAABBCCDD};
`ifdef DMEM_ARB_RR_EN
      vecs[6] = '{1'b1, 1'b1, 32'h14, 32'h11111111, 1'b1, 1'b1, 32'h18, 32'h22222222,
                  1'b1, 1'b1, 32'h18, 32'h22222222, 32'hAABBCCDD};
`else
      vecs[6] = '{1'b1, 1'b1, 32'h14, 32'h11111111, 1'b1, 1'b1, 32'h18, 32'h22222222,
                  1'b0, 1'b1, 32'h14, 32'h11111111, 32'hAABBCCDD};
`endif
      vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h03, 32'h0BADF00D,
                  1'b1, 1'b0, 32'h03, 32'h0BADF00D, 32'hAABBCCDD};

      rst_n = 1'b0;
      clear_inputs();
      #2;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table-driven single transactions ----------------
      for (int i = 0; i < 8; i++) begin
         string t;
         t = $sformatf("v%0d", i);
         @(negedge clk);
         chk({t, "_pre_busy"}, {31'd0, bus.busy}, 32'd0);
         bus.req0 = vecs[i].r0; bus.we0 = vecs[i].w0;
         bus.addr0 = vecs[i].a0; bus.wdata0 = vecs[i].d0;
         bus.req1 = vecs[i].r1; bus.we1 = vecs[i].w1;
         bus.addr1 = vecs[i].a1; bus.wdata1 = vecs[i].d1;
         @(negedge clk);  // ACCESS
         chk({t, "_acc_busy"},  {31'd0, bus.busy}, 32'd1);
         chk({t, "_acc_owner"}, {31'd0, bus.owner}, {31'd0, vecs[i].eo});
         chk({t, "_acc_mwr"},   {31'd0, bus.mem_write}, {31'd0, vecs[i].ewe});
         chk({t, "_acc_mrd"},   {31'd0, bus.mem_read}, {31'd0, ~vecs[i].ewe});
         chk({t, "_acc_maddr"}, bus.mem_address, vecs[i].ea);
         chk({t, "_acc_mwd"},   bus.mem_write_data, vecs[i].ed);
         chk({t, "_acc_acks"},  {30'd0, bus.ack1, bus.ack0}, 32'd0);
         @(negedge clk);  // RESP
         chk({t, "_resp_ack0"},  {31'd0, bus.ack0}, {31'd0, ~vecs[i].eo});
         chk({t, "_resp_ack1"},  {31'd0, bus.ack1}, {31'd0, vecs[i].eo});
         chk({t, "_resp_rdata"}, bus.rdata, vecs[i].erd);
         chk({t, "_resp_mstb"},  {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
         chk({t, "_resp_maddr"}, bus.mem_address, 32'd0);
         chk({t, "_resp_busy"},  {31'd0, bus.busy}, 32'd1);
         clear_inputs();
         @(negedge clk);  // back in IDLE
         chk({t, "_idle_busy"},  {31'd0, bus.busy}, 32'd0);
         chk({t, "_idle_acks"},  {30'd0, bus.ack1, bus.ack0}, 32'd0);
         chk({t, "_idle_owner"}, {31'd0, bus.owner}, {31'd0, vecs[i].eo});
         if (vecs[i].ewe) chk({t, "_memword"}, mem[vecs[i].ea[7:2]], vecs[i].ed);
      end

      // ---------------- reset during ACCESS of a write ----------------
      chk("rstacc_pre_word8", mem[8], 32'h5A5A5A5A);
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'hDEADBEEF;
      @(negedge clk);
      chk("rstacc_mwr_before", {31'd0, bus.mem_write}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_vals("rstacc");
      @(posedge clk);
      @(negedge clk);
      chk("rstacc_word8", mem[8], 32'h5A5A5A5A);
      chk("rstacc_ack0_held", {31'd0, bus.ack0}, 32'd0);
      clear_inputs();
      rst_n = 1'b1;
      begin
         logic seen = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | bus.ack0 | bus.ack1 | bus.busy;
         end
         chk("rstacc_no_ack_after", {31'd0, seen}, 32'd0);
      end

      // ---------------- requester input change after grant ----------------
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
      @(posedge clk);
      #1 bus.addr0 = 32'h40;
      @(negedge clk);
      chk("chg_maddr", bus.mem_address, 32'h10);
      chk("chg_mrd", {31'd0, bus.mem_read}, 32'd1);
      @(negedge clk);
      chk("chg_ack0", {31'd0, bus.ack0}, 32'd1);
      chk("chg_rdata", bus.rdata, 32'h12345678);
      clear_inputs();
      wait_idle("chg");

      // ---------------- contention after reset ----------------
      @(negedge clk);
      rst_n = 1'b0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h00;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h10;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("cont_first_busy",  {31'd0, bus.busy}, 32'd1);
      chk("cont_first_owner", {31'd0, bus.owner}, 32'd0);
      begin
         logic [1:0] seq;
         int         n_ack = 0;
         logic       both = 1'b0;
         seq = 2'b11;
         for (int k = 0; k < 12 && n_ack < 2; k++) begin
            @(negedge clk);
            both = both | (bus.ack0 & bus.ack1);
            if (bus.ack0 || bus.ack1) begin
               seq[n_ack] = bus.ack1;
               n_ack++;
            end
         end
         clear_inputs();
         chk("cont_ack_count", n_ack, 32'd2);
         chk("cont_both_acks", {31'd0, both}, 32'd0);
         chk("cont_first_ack", {31'd0, seq[0]}, 32'd0);
`ifdef DMEM_ARB_RR_EN
         chk("cont_second_ack", {31'd0, seq[1]}, 32'd1);
`else
         chk("cont_second_ack", {31'd0, seq[1]}, 32'd0);
`endif
      end
      wait_idle("cont");

      // ---------------- back-to-back requests ----------------
      @(negedge clk);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h00;
      begin
         logic [9:1] ackb;
         logic [9:1] busyb;
         logic       any1 = 1'b0;
         for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ackb[k]  = bus.ack0;
            busyb[k] = bus.busy;
            any1     = any1 | bus.ack1;
            if (k == 8) bus.req0 = 1'b0;
         end
         chk("b2b_ack0_pattern", {23'd0, ackb}, {23'd0, 9'b010010010});
         chk("b2b_busy_pattern", {23'd0, busyb}, {23'd0, 9'b011011011});
         chk("b2b_no_ack1", {31'd0, any1}, 32'd0);
         chk("b2b_rdata", bus.rdata, 32'hAABBCCDD);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width of every address port.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width of every data port.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read, for requester 0/1.
REQ-007 The block SHALL have ports addr0/addr1  input  ADDR_W  byte address from requester 0/1.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DATA_W  write data from requester 0/1.
REQ-009 The block SHALL have ports ack0/ack1  output  1  one-cycle completion pulse to requester 0/1.
REQ-010 The block SHALL have port rdata  output  DATA_W  read result, valid while the acknowledged transaction was a read.
REQ-011 The block SHALL have ports busy  output  1  (transaction in flight) and owner  output  1  (index of current or last granted requester).
REQ-012 The block SHALL have ports mem_address  output  ADDR_W, mem_write_data  output  DATA_W, mem_read  output  1, mem_write  output  1, mem_read_data  input  DATA_W, driving the shared data memory (combinational read, write on rising clk).

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high at the edge, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-014 On IDLE->ACCESS the block SHALL latch the winner's index, we, addr and wdata; later changes on requester inputs SHALL NOT affect the transaction.
REQ-015 In ACCESS exactly one cycle: mem_address = latched addr unchanged (low 2 bits passed through), mem_write_data = latched wdata, mem_write = latched we, mem_read = not latched we.
REQ-016 Outside ACCESS, mem_read, mem_write, mem_address and mem_write_data SHALL be 0.
REQ-017 At the ACCESS->RESP edge, rdata SHALL capture mem_read_data for reads and hold its previous value for writes.
REQ-018 In RESP the winner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0; at most one ack high in any cycle.
REQ-019 Latency: req sampled at edge E0 -> mem strobe during E0..E1 -> ack during E1..E2; one transaction per 3 cycles maximum.
REQ-020 Requesters SHALL hold req/we/addr/wdata until ack; req still high at the first IDLE edge after ack SHALL be treated as a new request.
REQ-021 busy SHALL be 1 in ACCESS and RESP, 0 in IDLE; owner SHALL update only on IDLE->ACCESS.
REQ-022 A single requesting port SHALL always be granted; simultaneous requests SHALL be resolved per REQ-027/REQ-028; the loser SHALL keep waiting with no ack.

Reset
REQ-023 While rst_n = 0 the block SHALL immediately force state IDLE, ack0 = ack1 = 0, busy = 0, mem_read = mem_write = 0, mem_address = mem_write_data = 0, rdata = 0, owner = 0.
REQ-024 Reset asserted in ACCESS SHALL deassert mem_write before the next edge so no write commits; the aborted transaction SHALL receive no ack.
REQ-025 After rst_n rises, the first arbitration SHALL occur at the first rising clk edge with rst_n = 1.
REQ-026 The round-robin pointer, when present, SHALL reset so that requester 0 wins the first simultaneous request.

Configuration
REQ-027 With macro DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last (round-robin, pointer updated on each grant).
REQ-028 Without DMEM_ARB_RR_EN, simultaneous requests SHALL always be granted to requester 0 (fixed priority) and no pointer register SHALL exist.

Verification
REQ-029 Single write: req0=1, we0=1, addr0=0x10, wdata0=0x12345678 -> mem_write=1 with mem_address=0x10 for one cycle, ack0 one cycle later, memory word 4 = 0x12345678.
REQ-030 Single read: req1=1, we1=0, addr1=0x0, memory word 0 = 0xAABBCCDD -> mem_read one cycle, ack1 with rdata=0xAABBCCDD, ack0 stays 0.
REQ-031 Contention: req0=req1=1 held across two transactions -> with DMEM_ARB_RR_EN acks in order 0,1; without it ack0 for both and ack1 never.
REQ-032 Back-to-back: req0 held high through 3 transactions -> ack0 every 3rd cycle, busy low exactly one cycle between transactions.
REQ-033 Reset in ACCESS of write wdata0=0xDEADBEEF to addr0=0x20 -> mem_write drops asynchronously, no ack0, memory word 8 unchanged, all outputs at reset values.
REQ-034 Input change after grant: addr0 changed 0x10->0x40 during ACCESS -> mem_address stays 0x10.
